// File: rtl/skinny_pkg.sv
`default_nettype none
// ============================================================================
// Module      : skinny_pkg
// Description : Shared types and constants for the serial SKINNY S8 layer.
// Revision    : 1.0
// ============================================================================
package skinny_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int STATE_BYTES = 16;

    // Lane counts must divide the 16-byte state into a whole number of rotations.
    function automatic bit lanes_legal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
               (lanes == 8) || (lanes == 16);
    endfunction

endpackage
`default_nettype wire

// File: rtl/skinny_sbox8_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : skinny_sbox8_serial_if
// Description : Valid/ready state-in and result-out bundle for the S8 layer.
// Revision    : 1.0
// ============================================================================
interface skinny_sbox8_serial_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    modport master (
        output in_valid, in_state, in_inv, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, in_inv, out_ready,
        output in_ready, out_valid, out_state
    );

endinterface
`default_nettype wire

// File: rtl/skinny_sbox8_lane.sv
`default_nettype none
// ============================================================================
// Module      : skinny_sbox8_lane
// Description : Combinational SKINNY-128 S8 / S8^-1 built from NOR-XOR rounds.
// Revision    : 1.0
// ============================================================================
module skinny_sbox8_lane (
    input  logic       i_inv,
    input  logic [7:0] i_x,
    output logic [7:0] o_y
);

    // One NOR-XOR step; an involution, so it serves both directions.
    function automatic logic [7:0] f_mix(input logic [7:0] x);
        logic [7:0] y;
        y    = x;
        y[0] = x[0] ^ ~(x[3] | x[2]);
        y[4] = x[4] ^ ~(x[7] | x[6]);
        return y;
    endfunction

    function automatic logic [7:0] f_perm(input logic [7:0] x);
        return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
    endfunction

    function automatic logic [7:0] f_perm_inv(input logic [7:0] x);
        return {x[5], x[4], x[0], x[3], x[1], x[7], x[6], x[2]};
    endfunction

    function automatic logic [7:0] f_swap(input logic [7:0] x);
        return {x[7:3], x[1], x[2], x[0]};
    endfunction

    logic [7:0] w_fwd;
    logic [7:0] w_inv;

    assign w_fwd = f_swap(f_mix(f_perm(f_mix(f_perm(f_mix(f_perm(f_mix(i_x))))))));
    assign w_inv = f_mix(f_perm_inv(f_mix(f_perm_inv(f_mix(f_perm_inv(f_mix(f_swap(i_x))))))));
    assign o_y   = i_inv ? w_inv : w_fwd;

endmodule
`default_nettype wire

// File: rtl/skinny_sbox8_serial.sv
`default_nettype none
// ============================================================================
// Module      : skinny_sbox8_serial
// Description : Serialised 16-byte SKINNY S8 layer, LANES bytes per cycle.
// Revision    : 1.0
// ============================================================================
module skinny_sbox8_serial #(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    skinny_sbox8_serial_if.slave bus
);

    import skinny_pkg::*;

    localparam int C_STEPS = STATE_BYTES / LANES;
    localparam int C_CNT_W = (C_STEPS > 1) ? $clog2(C_STEPS) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_STEPS - 1);

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("skinny_sbox8_serial: LANES=%0d must be 1, 2, 4, 8 or 16", LANES);
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [127:0]         r_data;
    logic                 r_inv;
    logic                 w_in_ready;
    logic                 w_accept;
    logic [8*LANES-1:0]   w_sub;
    logic [127:0]         w_data_rot;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        skinny_sbox8_lane u_lane (
            .i_inv (r_inv),
            .i_x   (r_data[8*i +: 8]),
            .o_y   (w_sub[8*i +: 8])
        );
    end

    // Substituted bytes re-enter at the top so the full rotation restores order.
    if (LANES == STATE_BYTES) begin : g_rot_full
        assign w_data_rot = w_sub;
    end else begin : g_rot_part
        assign w_data_rot = {w_sub, r_data[127:8*LANES]};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    w_state_nxt = bus.in_valid ? ST_BUSY : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = bus.in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data <= bus.in_state;
                r_inv  <= bus.in_inv;
                r_cnt  <= '0;
            end else if (r_state == ST_BUSY) begin
                r_data <= w_data_rot;
                // Saturate at the terminal count so the counter never wraps.
                if (r_cnt != C_CNT_LAST) begin
                    r_cnt <= r_cnt + C_CNT_W'(1);
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_state = r_data;

endmodule
`default_nettype wire

// File: tb/tb_skinny_sbox8_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_skinny_sbox8_serial
// Description : Directed checks of the S8 layer for every legal LANES value.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_skinny_sbox8_serial;

    localparam int NDUT = 5;   // instance k runs with LANES = 1 << k

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid  [NDUT];
    logic [127:0] in_state  [NDUT];
    logic         in_inv    [NDUT];
    logic         out_ready [NDUT];
    logic [NDUT-1:0] in_ready_v;
    logic [NDUT-1:0] out_valid_v;
    logic [127:0] out_state_a [NDUT];

    int total = 0;
    int bad   = 0;

    logic [7:0] b2b_src [4] = '{8'h00, 8'h01, 8'h02, 8'hFF};
    logic [7:0] b2b_exp [4] = '{8'h65, 8'h4C, 8'h6A, 8'hFF};

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        skinny_sbox8_serial_if u_if ();
        assign u_if.in_valid  = in_valid[g];
        assign u_if.in_state  = in_state[g];
        assign u_if.in_inv    = in_inv[g];
        assign u_if.out_ready = out_ready[g];
        assign in_ready_v[g]  = u_if.in_ready;
        assign out_valid_v[g] = u_if.out_valid;
        assign out_state_a[g] = u_if.out_state;

        skinny_sbox8_serial #(.LANES(1 << g)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if)
        );
    end

    function automatic logic [127:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat counts rising edges from the accept edge (inclusive) to first out_valid.
    task automatic xact(input int k, input logic [127:0] st, input logic inv,
                        output logic [127:0] res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready_v[k] && guard < 40) begin
            tick();
            guard++;
        end
        in_valid[k]  = 1'b1;
        in_state[k]  = st;
        in_inv[k]    = inv;
        out_ready[k] = 1'b0;
        tick();
        in_valid[k] = 1'b0;
        in_state[k] = '0;
        lat = 1;
        while (!out_valid_v[k] && lat < 40) begin
            tick();
            lat++;
        end
        res = out_state_a[k];
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] res2;
        logic [127:0] rnd;
        int           lat;
        int           sent;
        int           rcv;
        int           last_c;
        int           w;
        bit           acc;
        bit           seen;
        logic [127:0] held;

        for (int k = 0; k < NDUT; k++) begin
            in_valid[k]  = 1'b0;
            in_state[k]  = '0;
            in_inv[k]    = 1'b0;
            out_ready[k] = 1'b0;
        end

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_in_ready",  128'(in_ready_v[k]),  128'd1);
            chk("rst_out_valid", 128'(out_valid_v[k]), 128'd0);
            chk("rst_out_state", out_state_a[k], 128'd0);
        end
        rst = 1'b0;
        tick();

        // LANES=4 forward on uniform states
        xact(2, rep(8'h00), 1'b0, res, lat);
        chk("l4_zero_data", res, rep(8'h65));
        chk("l4_zero_lat",  128'(lat), 128'd5);
        xact(2, rep(8'hFF), 1'b0, res, lat);
        chk("l4_ff_data", res, rep(8'hFF));

        // LANES=1 distinct bytes, latency 17
        xact(0, {{13{8'h00}}, 8'h02, 8'h01, 8'h00}, 1'b0, res, lat);
        chk("l1_vec_data", res, {{13{8'h65}}, 8'h6A, 8'h4C, 8'h65});
        chk("l1_vec_lat",  128'(lat), 128'd17);

        // Every LANES: known forward value, latency, inverse round trip
        for (int k = 0; k < NDUT; k++) begin
            xact(k, rep(8'h00), 1'b0, res, lat);
            chk("all_fwd_zero", res, rep(8'h65));
            chk("all_fwd_lat",  128'(lat), 128'((16 >> k) + 1));
            rnd = {$urandom, $urandom, $urandom, $urandom};
            xact(k, rnd, 1'b0, res, lat);
            xact(k, res, 1'b1, res2, lat);
            chk("all_roundtrip", res2, rnd);
            xact(k, rep(8'h65), 1'b1, res, lat);
            chk("all_inv_65", res, rep(8'h00));
        end

        // Back-to-back streaming on LANES=4
        sent   = 0;
        rcv    = 0;
        last_c = 0;
        out_ready[2] = 1'b1;
        in_valid[2]  = 1'b1;
        in_inv[2]    = 1'b0;
        in_state[2]  = rep(b2b_src[0]);
        for (int c = 0; c < 60; c++) begin
            acc = in_valid[2] && in_ready_v[2];
            if (out_valid_v[2]) begin
                if (rcv < 4) chk("b2b_data", out_state_a[2], rep(b2b_exp[rcv]));
                if (rcv > 0) chk("b2b_gap", 128'(c - last_c), 128'd5);
                last_c = c;
                rcv++;
            end
            tick();
            if (acc) begin
                sent++;
                if (sent < 4) in_state[2] = rep(b2b_src[sent]);
                else          in_valid[2] = 1'b0;
            end
        end
        chk("b2b_count", 128'(rcv), 128'd4);
        out_ready[2] = 1'b0;
        in_valid[2]  = 1'b0;
        tick();

        // Backpressure: result held while out_ready is low, new offers ignored
        in_valid[2] = 1'b1;
        in_state[2] = rep(8'h01);
        in_inv[2]   = 1'b0;
        tick();
        in_state[2] = rep(8'h02);
        w = 0;
        while (!out_valid_v[2] && w < 40) begin
            tick();
            w++;
        end
        chk("bp_lat",  128'(w + 1), 128'd5);
        chk("bp_data", out_state_a[2], rep(8'h4C));
        held = out_state_a[2];
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_hold_data",  out_state_a[2], held);
            chk("bp_in_ready",   128'(in_ready_v[2]),  128'd0);
            chk("bp_out_valid",  128'(out_valid_v[2]), 128'd1);
        end
        in_valid[2]  = 1'b0;
        out_ready[2] = 1'b1;
        tick();
        out_ready[2] = 1'b0;
        chk("bp_back_idle", 128'(in_ready_v[2]), 128'd1);

        // Reset asserted on the second BUSY cycle
        in_valid[2] = 1'b1;
        in_state[2] = rep(8'hFF);
        tick();
        in_valid[2] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready",  128'(in_ready_v[2]),  128'd1);
        chk("mid_rst_out_valid", 128'(out_valid_v[2]), 128'd0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid_v[2]) seen = 1'b1;
        end
        chk("mid_rst_no_valid", 128'(seen), 128'd0);
        xact(2, rep(8'h01), 1'b0, res, lat);
        chk("post_rst_data", res, rep(8'h4C));
        chk("post_rst_lat",  128'(lat), 128'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/skinny_sbox8_serial.md
SKINNY_SBOX8_SERIAL -- requirements
Module: skinny_sbox8_serial

Interface
REQ-001 SHALL have parameter LANES, default 4, giving the number of S-box lanes (bytes substituted per cycle); legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the input state is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a state.
REQ-006 SHALL have port in_state, input, 128 bits: 16 bytes, where byte i is in_state[8i+7:8i].
REQ-007 SHALL have port in_inv, input, 1 bit: 0 selects the forward SKINNY S8; 1 selects the inverse S8. It is sampled at accept.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is held.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port out_state, output, 128 bits: the substituted state, in the same byte order as in_state.

Function
REQ-011 SHALL compute out byte i = S8(in byte i), or S8^-1(in byte i) when inv=1, for all 16 bytes.
REQ-012 SHALL implement an FSM with three states:
- IDLE: in_ready=1, out_valid=0.
- BUSY: in_ready=0, out_valid=0.
- DONE: out_valid=1.
REQ-013 SHALL define accept as the cycle in which in_valid and in_ready are both 1. On accept it loads in_state into a 128-bit register, latches in_inv, clears the round counter, and enters BUSY.
REQ-014 SHALL, in each BUSY cycle:
- substitute the LANES lowest bytes of the register;
- rotate the register right by 8*LANES bits, so the substituted bytes enter at the top;
- increment the counter.
REQ-015 SHALL leave BUSY for DONE after exactly 16/LANES BUSY cycles, at which point every byte sits in its original position.
REQ-016 SHALL therefore present out_valid exactly 16/LANES+1 cycles after the accept edge (LANES=16: 2 cycles; LANES=1: 17 cycles).
REQ-017 SHALL size the counter at max(1, clog2(16/LANES)) bits; for every legal LANES the counter reaches its terminal value exactly once per transaction and does not wrap.
REQ-018 SHALL hold out_state and out_valid stable in DONE until out_ready=1.
REQ-019 SHALL drive in_ready = IDLE OR (DONE AND out_ready), so that a new state can be accepted in the same cycle the old result is taken.
REQ-020 SHALL move from DONE to BUSY on out_ready=1 with in_valid=1 (new accept); on out_ready=1 with in_valid=0 it moves to IDLE.
REQ-021 SHALL ignore in_valid, in_state and in_inv while in BUSY.
REQ-022 SHALL drive out_state from the working register, whose value is meaningful only while out_valid=1.
REQ-023 SHALL contain no combinational path from in_valid or in_state to out_valid or out_state.

Reset
REQ-024 SHALL, when rst=1 at a clock edge:
- set the FSM to IDLE;
- set the counter to 0;
- clear the working register and the inv latch to 0;
- set out_valid=0 and in_ready=1 from the following cycle.
REQ-025 SHALL, on a reset asserted mid-BUSY or in DONE, abort and discard the transaction; no out_valid pulse follows.
REQ-026 SHALL give rst priority over every simultaneous handshake event.

Structure
REQ-027 SHALL place in a shared package skinny_pkg:
- the FSM state enum (IDLE, BUSY, DONE);
- the constant STATE_BYTES = 16;
- the legal-LANES check as an elaboration-time assertion.
REQ-028 SHALL instantiate the sub-module skinny_sbox8_lane LANES times; each instance is a combinational 8-bit forward/inverse S8 with an inv select, built as a low-depth logic network (no table ROM).
REQ-029 SHALL keep all registers in the top module; the lanes contain no state.

Verification
REQ-030 SHALL cover, with LANES=4: in_state all 0x00, inv=0 -> after 5 cycles out_state all bytes 0x65; in_state all 0xFF -> all bytes 0xFF.
REQ-031 SHALL cover, with LANES=1: bytes 0x00,0x01,0x02 at byte positions 0,1,2, all other bytes 0x00 -> out bytes 0x65,0x4C,0x6A, others 0x65, with out_valid at cycle 17 after accept.
REQ-032 SHALL cover an inverse round-trip for each legal LANES: a random state is sent with inv=0 and the result is fed back with inv=1 -> the original state is returned; inv=1 on all bytes 0x65 -> all bytes 0x00.
REQ-033 SHALL cover back-to-back traffic: out_ready held 1 and in_valid held 1 -> one result every 16/LANES+1 cycles, no IDLE gap, no lost or duplicated transaction.
REQ-034 SHALL cover backpressure: out_ready=0 for 10 cycles in DONE -> out_state stable and in_ready=0 throughout.
REQ-035 SHALL cover reset: rst=1 on the 2nd BUSY cycle -> next cycle IDLE with in_ready=1, no out_valid, and the next transaction is correct.
